// File: rtl/loc_bus_pkg.sv
// loc_bus_pkg: shared widths, FSM encodings and address-decode helpers for the local bus target
package loc_bus_pkg;

    localparam int LAD_W = 32;
    localparam int IDX_W = 4;

    typedef enum logic [5:0] {
        T_IDLE  = 6'b000001,
        T_RTURN = 6'b000010,
        T_RDATA = 6'b000100,
        T_RACK  = 6'b001000,
        T_WDATA = 6'b010000,
        T_WACK  = 6'b100000
    } tstate_e;

    function automatic logic addr_hit(input logic [LAD_W-1:0] addr,
                                      input logic [LAD_W-1:0] base,
                                      input logic [LAD_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [LAD_W-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

endpackage

// File: rtl/loc_bus_tgt_regfile.sv
// loc_bus_tgt_regfile: NREG x 32 register bank with one write port and one read mux
module loc_bus_tgt_regfile
    import loc_bus_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [LAD_W-1:0]       wdata_i,
    output logic [LAD_W-1:0]       rdata_o,
    output logic [NREG*LAD_W-1:0]  regs_o
);

    logic [LAD_W-1:0] mem_q [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        // Indices at or above NREG match no register, so such writes are dropped
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) mem_q[i] <= '0;
            else if (we_i && idx_i == IDX_W'(i)) mem_q[i] <= wdata_i;
        end
        assign regs_o[LAD_W*i +: LAD_W] = mem_q[i];
    end

    // Read mux returns zero for unimplemented indices
    always_comb begin
        rdata_o = '0;
        for (int j = 0; j < NREG; j++) rdata_o = idx_i == IDX_W'(j) ? mem_q[j] : rdata_o;
    end

endmodule

// File: rtl/loc_bus_target.sv
// loc_bus_target: local-bus responder granting the bus and serving single reads/writes from a register bank
module loc_bus_target
    import loc_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFC0,
    parameter int          NREG        = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  CLOCK,
    input  logic                  RESETn,
    input  logic                  LHOLD,
    output logic                  LHOLDA,
    input  logic                  LOC_BUSY,
    input  logic                  ADSn,
    input  logic                  LW_Rn,
    inout  wire  [LAD_W-1:0]      LAD_BUS,
    output logic                  READYn,
    output logic [NREG*LAD_W-1:0] REG_OUT,
    output logic                  WR_STROBE,
    output logic [IDX_W-1:0]      WR_INDEX,
    output logic                  ERR_FLAG
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    tstate_e          state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             turn_q, turn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lholda_q, lholda_d;
    logic             readyn_q, readyn_d;
    logic             oe_q, oe_d;
    logic [LAD_W-1:0] lad_q, lad_d;
    logic             strobe_q, strobe_d;
    logic [IDX_W-1:0] wr_index_q, wr_index_d;
    logic             err_q, err_d;
    logic             ads_ok;
    logic [LAD_W-1:0] rdata;

    assign ads_ok = !ADSn && lholda_q && addr_hit(LAD_BUS, BASE_ADDR, ADDR_MASK);

    loc_bus_tgt_regfile #(.NREG(NREG)) u_regfile (
        .clk_i   (CLOCK),
        .rst_ni  (RESETn),
        .we_i    (state_q == T_WACK),
        .idx_i   (idx_q),
        .wdata_i (LAD_BUS),
        .rdata_o (rdata),
        .regs_o  (REG_OUT)
    );

    // Transfer FSM; the first T_WDATA clock is bus turnaround so both directions end at k+3+W
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        turn_d  = 1'b0;
        idx_d   = idx_q;
        case (state_q)
            T_IDLE: if (ads_ok) begin
                state_d = LW_Rn ? T_WDATA : T_RTURN;
                cnt_d   = WS;
                turn_d  = LW_Rn;
                idx_d   = addr_idx(LAD_BUS);
            end
            T_RTURN: state_d = T_RDATA;
            T_RDATA, T_WDATA: if (!turn_q) begin
                state_d = cnt_q != 4'd0 ? state_q : (state_q == T_RDATA ? T_RACK : T_WACK);
                cnt_d   = cnt_q - 4'd1;
            end
            T_RACK, T_WACK: state_d = T_IDLE;
            default: state_d = T_IDLE;
        endcase
    end

    // Grant, handshake and status next values; every output leaves a flop
    always_comb begin
        lholda_d   = lholda_q ? (LHOLD || state_q != T_IDLE) : (LHOLD && !LOC_BUSY);
        readyn_d   = !(state_d == T_RACK || state_d == T_WACK);
        oe_d       = state_d == T_RDATA || state_d == T_RACK;
        lad_d      = rdata;
        strobe_d   = state_q == T_WACK;
        wr_index_d = strobe_d ? idx_q : wr_index_q;
        err_d      = err_q || (!ADSn && state_q != T_IDLE);
    end

    // All state and output registers; async reset aborts any transfer in flight
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= T_IDLE;
            cnt_q      <= '0;
            turn_q     <= 1'b0;
            idx_q      <= '0;
            lholda_q   <= 1'b0;
            readyn_q   <= 1'b1;
            oe_q       <= 1'b0;
            lad_q      <= '0;
            strobe_q   <= 1'b0;
            wr_index_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            turn_q     <= turn_d;
            idx_q      <= idx_d;
            lholda_q   <= lholda_d;
            readyn_q   <= readyn_d;
            oe_q       <= oe_d;
            lad_q      <= lad_d;
            strobe_q   <= strobe_d;
            wr_index_q <= wr_index_d;
            err_q      <= err_d;
        end
    end

    assign LAD_BUS   = oe_q ? lad_q : {LAD_W{1'bz}};
    assign LHOLDA    = lholda_q;
    assign READYn    = readyn_q;
    assign WR_STROBE = strobe_q;
    assign WR_INDEX  = wr_index_q;
    assign ERR_FLAG  = err_q;

endmodule
